multi_shift_register: RTL

Parametrised shift/rotate register: parallel load plus multi-step rotate, logical shift and arithmetic shift by a programmable amount, one bit position per clock. A small state machine with a start/busy/done handshake runs each operation. This is the general-width, multi-mode successor to the 8-bit rotating register for lab datapaths that feed shifter results to the display and ALU stages.

---
 rtl/multi_shift_register.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/multi_shift_register.sv
`default_nettype none
// ============================================================================
// Module      : multi_shift_register
// Description : Parameterised shift/rotate register with parallel load and a
//               start/busy/done handshake, one bit position per clock.
// Revision    : 1.0 - initial release
// ============================================================================
module multi_shift_register #(
    parameter int WIDTH = 8,
    parameter int AMT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [AMT_W-1:0] amount,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] q,
    output logic             carry_out,
    output logic             busy,
    output logic             done,
    output logic             err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [2:0]       c_OP_ROL = 3'b000;
    localparam logic [2:0]       c_OP_ROR = 3'b001;
    localparam logic [2:0]       c_OP_LSL = 3'b010;
    localparam logic [2:0]       c_OP_LSR = 3'b011;
    localparam logic [2:0]       c_OP_ASR = 3'b100;
    localparam logic [AMT_W-1:0] c_AMT_ZERO = '0;
    localparam logic [AMT_W-1:0] c_AMT_ONE  = {{(AMT_W-1){1'b0}}, 1'b1};

    state_t             r_state;
    state_t             w_state_next;
    logic [AMT_W-1:0]   r_count;
    logic [AMT_W-1:0]   w_count_next;
    logic [2:0]         r_op;
    logic [2:0]         w_op_next;
    logic               r_illegal;
    logic               w_illegal_next;
    logic [WIDTH-1:0]   r_q;
    logic [WIDTH-1:0]   w_q_next;
    logic               r_carry;
    logic               w_carry_next;
    logic [WIDTH-1:0]   w_step_q;
    logic               w_step_c;
    logic               w_op_illegal;

    // Codes 101..111 have no defined operation.
    assign w_op_illegal = op[2] && (op[1:0] != 2'b00);

    // Single-step result for the latched operation.
    always_comb begin
        w_step_q = r_q;
        w_step_c = r_carry;
        case (r_op)
            c_OP_ROL: begin
                w_step_q = {r_q[WIDTH-2:0], r_q[WIDTH-1]};
                w_step_c = r_q[WIDTH-1];
            end
            c_OP_ROR: begin
                w_step_q = {r_q[0], r_q[WIDTH-1:1]};
                w_step_c = r_q[0];
            end
            c_OP_LSL: begin
                w_step_q = {r_q[WIDTH-2:0], 1'b0};
                w_step_c = r_q[WIDTH-1];
            end
            c_OP_LSR: begin
                w_step_q = {1'b0, r_q[WIDTH-1:1]};
                w_step_c = r_q[0];
            end
            c_OP_ASR: begin
                w_step_q = {r_q[WIDTH-1], r_q[WIDTH-1:1]};
                w_step_c = r_q[0];
            end
            default: begin
                w_step_q = r_q;
                w_step_c = r_carry;
            end
        endcase
    end

    always_comb begin
        w_state_next   = r_state;
        w_count_next   = r_count;
        w_op_next      = r_op;
        w_illegal_next = r_illegal;
        w_q_next       = r_q;
        w_carry_next   = r_carry;
        case (r_state)
            S_IDLE: begin
                if (!load_n) begin
                    w_q_next     = data_in;
                    w_carry_next = 1'b0;
                end else if (start) begin
                    w_op_next      = op;
                    w_illegal_next = w_op_illegal;
                    if (w_op_illegal || (amount == c_AMT_ZERO)) begin
                        w_state_next = S_DONE;
                    end else begin
                        w_count_next = amount;
                        w_state_next = S_RUN;
                    end
                end
            end
            S_RUN: begin
                w_q_next     = w_step_q;
                w_carry_next = w_step_c;
                w_count_next = r_count - c_AMT_ONE;
                if (r_count == c_AMT_ONE) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_count   <= '0;
            r_op      <= '0;
            r_illegal <= 1'b0;
            r_q       <= '0;
            r_carry   <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_count   <= w_count_next;
            r_op      <= w_op_next;
            r_illegal <= w_illegal_next;
            r_q       <= w_q_next;
            r_carry   <= w_carry_next;
        end
    end

    assign q         = r_q;
    assign carry_out = r_carry;
    assign busy      = (r_state != S_IDLE);
    assign done      = (r_state == S_DONE);
    assign err       = (r_state == S_DONE) && r_illegal;

endmodule
`default_nettype wire
